// File: rtl/axi_sub_arb_mp.sv
// NRQ-way round-robin arbiter with burst locking and latency-matched read-return routing.
// Optional per-requester grant counters are built when AXI_SUB_ARB_MP_PERF_EN is defined.
module axi_sub_arb_mp #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int BC    = DW / 8,
  parameter int UW    = 32,
  parameter int IW    = 1,
  parameter int NRQ   = 3,
  parameter int C_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRQ-1:0]    req_dv,
  input  logic [NRQ-1:0]    req_write,
  input  logic [NRQ*AW-1:0] req_addr,
  input  logic [NRQ*UW-1:0] req_user,
  input  logic [NRQ*IW-1:0] req_id,
  input  logic [NRQ*DW-1:0] req_wdata,
  input  logic [NRQ*BC-1:0] req_wstrb,
  input  logic [NRQ-1:0]    req_last,
  output logic [NRQ-1:0]    req_hld,
  output logic [NRQ-1:0]    req_wr_err,
  output logic [NRQ-1:0]    req_rvalid,
  output logic [NRQ-1:0]    req_rd_err,
  output logic [DW-1:0]     req_rdata,
  output logic              dv,
  output logic              write,
  output logic [AW-1:0]     addr,
  output logic [UW-1:0]     user,
  output logic [IW-1:0]     id,
  output logic [DW-1:0]     wdata,
  output logic [BC-1:0]     wstrb,
  output logic              last,
  input  logic              hld,
  input  logic              rd_err,
  input  logic              wr_err,
  input  logic [DW-1:0]     rdata,
  input  logic              perf_clr,
  output logic [NRQ*16-1:0] perf_cnt
);

  localparam int PW = (NRQ > 1) ? $clog2(NRQ) : 1;

  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    owner;
  logic             lock;
  logic [PW-1:0]    win;
  logic             win_vld;
  logic [2*NRQ-1:0] dv_rot;
  int               cand;
  logic             accept;
  logic             rd_push;
  logic             ret_vld;
  logic [PW-1:0]    ret_own;

  // Rotating the doubled request vector by rr_ptr turns the fair search into a
  // plain first-set-bit scan.
  always_comb begin
    win     = owner;
    win_vld = lock;
    cand    = 0;
    dv_rot  = {req_dv, req_dv} >> rr_ptr;
    if (!lock) begin
      for (int k = 0; k < NRQ; k++) begin
        if (!win_vld && dv_rot[k]) begin
          cand = int'(rr_ptr) + k;
          if (cand >= NRQ) cand = cand - NRQ;
          win_vld = 1'b1;
          win     = PW'(cand);
        end
      end
    end
  end

  always_comb begin
    dv    = 1'b0;
    write = 1'b0;
    addr  = '0;
    user  = '0;
    id    = '0;
    wdata = '0;
    wstrb = '0;
    last  = 1'b0;
    req_hld = '1;
    for (int i = 0; i < NRQ; i++) begin
      if (win_vld && win == PW'(i)) begin
        dv         = req_dv[i];
        write      = req_write[i];
        addr       = req_addr[i*AW +: AW];
        user       = req_user[i*UW +: UW];
        id         = req_id[i*IW +: IW];
        wdata      = req_wdata[i*DW +: DW];
        wstrb      = req_wstrb[i*BC +: BC];
        last       = req_last[i];
        req_hld[i] = hld;
      end
    end
  end

  assign accept  = dv & ~hld;
  assign rd_push = accept & ~write;

  always_comb begin
    req_wr_err = '0;
    for (int i = 0; i < NRQ; i++) begin
      if (accept && write && wr_err && win == PW'(i)) req_wr_err[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      lock   <= 1'b0;
      owner  <= '0;
    end else if (accept) begin
      if (last) begin
        lock   <= 1'b0;
        rr_ptr <= (win == PW'(NRQ - 1)) ? '0 : win + PW'(1);
      end else begin
        lock  <= 1'b1;
        owner <= win;
      end
    end
  end

  generate
    if (C_LAT == 0) begin : g_ret_comb
      assign ret_vld = rd_push;
      assign ret_own = win;
    end else begin : g_ret_pipe
      logic [C_LAT-1:0] ret_vld_p;
      logic [PW-1:0]    ret_own_p [C_LAT];
      // Return pipe stage boundary: free-running shift, independent of hld.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ret_vld_p <= '0;
          for (int s = 0; s < C_LAT; s++) ret_own_p[s] <= '0;
        end else begin
          ret_vld_p[0] <= rd_push;
          ret_own_p[0] <= win;
          for (int s = 1; s < C_LAT; s++) begin
            ret_vld_p[s] <= ret_vld_p[s-1];
            ret_own_p[s] <= ret_own_p[s-1];
          end
        end
      end
      assign ret_vld = ret_vld_p[C_LAT-1];
      assign ret_own = ret_own_p[C_LAT-1];
    end
  endgenerate

  always_comb begin
    req_rvalid = '0;
    req_rd_err = '0;
    for (int i = 0; i < NRQ; i++) begin
      if (ret_vld && ret_own == PW'(i)) begin
        req_rvalid[i] = 1'b1;
        req_rd_err[i] = rd_err;
      end
    end
  end

  assign req_rdata = rdata;

`ifdef AXI_SUB_ARB_MP_PERF_EN
  logic [15:0] perf_q [NRQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NRQ; i++) perf_q[i] <= '0;
    end else begin
      for (int i = 0; i < NRQ; i++) begin
        if (perf_clr) perf_q[i] <= '0;
        else if (accept && win == PW'(i) && perf_q[i] != 16'hFFFF) perf_q[i] <= perf_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    perf_cnt = '0;
    for (int i = 0; i < NRQ; i++) perf_cnt[i*16 +: 16] = perf_q[i];
  end
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign perf_cnt        = '0;
`endif

endmodule

// File: tb/tb_axi_sub_arb_mp.sv
// Scoreboard bench for axi_sub_arb_mp: one instance with C_LAT=0 and one with C_LAT=2 share stimulus.
// Define AXI_SUB_ARB_MP_PERF_EN to also exercise the grant counters.
module tb_axi_sub_arb_mp;

  localparam int NRQ = 3;

  logic        clk, rst;
  logic [2:0]  req_dv, req_write, req_last;
  logic [95:0] req_addr, req_user, req_wdata;
  logic [2:0]  req_id;
  logic [11:0] req_wstrb;
  logic        hld, rd_err, wr_err, perf_clr;
  logic [31:0] rdata;

  logic [2:0]  rh0, we0, rv0, re0, rh2, we2, rv2, re2;
  logic [31:0] rd0, rd2, ad0, ad2, us0, us2, wd0, wd2;
  logic        dv0, dv2, wr0, wr2, ls0, ls2;
  logic [0:0]  id0, id2;
  logic [3:0]  ws0, ws2;
  logic [47:0] pc0, pc2;

  axi_sub_arb_mp #(.NRQ(NRQ), .C_LAT(0)) u_d0 (
    .clk(clk), .rst(rst), .req_dv(req_dv), .req_write(req_write), .req_addr(req_addr),
    .req_user(req_user), .req_id(req_id), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_last(req_last), .req_hld(rh0), .req_wr_err(we0), .req_rvalid(rv0), .req_rd_err(re0),
    .req_rdata(rd0), .dv(dv0), .write(wr0), .addr(ad0), .user(us0), .id(id0), .wdata(wd0),
    .wstrb(ws0), .last(ls0), .hld(hld), .rd_err(rd_err), .wr_err(wr_err), .rdata(rdata),
    .perf_clr(perf_clr), .perf_cnt(pc0));

  axi_sub_arb_mp #(.NRQ(NRQ), .C_LAT(2)) u_d2 (
    .clk(clk), .rst(rst), .req_dv(req_dv), .req_write(req_write), .req_addr(req_addr),
    .req_user(req_user), .req_id(req_id), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_last(req_last), .req_hld(rh2), .req_wr_err(we2), .req_rvalid(rv2), .req_rd_err(re2),
    .req_rdata(rd2), .dv(dv2), .write(wr2), .addr(ad2), .user(us2), .id(id2), .wdata(wd2),
    .wstrb(ws2), .last(ls2), .hld(hld), .rd_err(rd_err), .wr_err(wr_err), .rdata(rdata),
    .perf_clr(perf_clr), .perf_cnt(pc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int rq; logic wr; logic lst; logic [31:0] wd; logic werr; } gnt_t;
  typedef struct { int rq; logic err; } ret_t;
  typedef struct { int kind; logic [47:0] exp; } prb_t;

  gnt_t gq[$];
  ret_t r0q[$];
  ret_t r2q[$];
  prb_t pq[$];

  int   n_cmp = 0;
  int   n_fail = 0;
  logic mon_en = 1'b1;
  logic done = 1'b0;
  logic fin = 1'b0;

  gnt_t g;
  ret_t r;
  prb_t p;
  logic [2:0] oh;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Expected grant (and its read return on each instance) in acceptance order.
  task automatic push_g(input int rq, input logic wr, input logic lst, input logic werr,
                        input logic e0, input logic e2, input logic r2);
    gnt_t ng;
    ret_t nr;
    ng.rq = rq; ng.wr = wr; ng.lst = lst; ng.werr = werr;
    ng.wd = req_wdata[rq*32 +: 32];
    gq.push_back(ng);
    if (!wr) begin
      nr.rq = rq; nr.err = e0;
      r0q.push_back(nr);
      if (r2) begin
        nr.err = e2;
        r2q.push_back(nr);
      end
    end
  endtask

  task automatic probe(input int kind, input logic [47:0] exp);
    prb_t np;
    np.kind = kind; np.exp = exp;
    pq.push_back(np);
  endtask

  task automatic cyc(input logic [2:0] dv, input logic [2:0] wr, input logic [2:0] lst,
                     input logic h, input logic we, input logic re);
    req_dv = dv; req_write = wr; req_last = lst;
    hld = h; wr_err = we; rd_err = re;
    rdata = $urandom;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_rvalid", 64'({rv0, rv2}), 64'd0);
    end else if (mon_en) begin
      while (pq.size() > 0) begin
        p = pq.pop_front();
        case (p.kind)
          0: begin chk("dv_c0", 64'(dv0), 64'(p.exp)); chk("dv_c2", 64'(dv2), 64'(p.exp)); end
          1: begin chk("req_hld_c0", 64'(rh0), 64'(p.exp)); chk("req_hld_c2", 64'(rh2), 64'(p.exp)); end
          2: begin chk("rvalid_c0", 64'(rv0), 64'(p.exp)); chk("rvalid_c2", 64'(rv2), 64'(p.exp)); end
          default: begin chk("perf_c0", 64'(pc0), 64'(p.exp)); chk("perf_c2", 64'(pc2), 64'(p.exp)); end
        endcase
      end
      if (dv0 && !hld) begin
        if (gq.size() == 0) begin
          chk("grant_unexpected", 64'(dv0), 64'd0);
        end else begin
          g  = gq.pop_front();
          oh = 3'b001 << g.rq;
          chk("dv_c2_on_accept", 64'(dv2), 64'd1);
          chk("addr_c0", 64'(ad0), 64'(32'h1000_0000 + 32'(g.rq * 16)));
          chk("addr_c2", 64'(ad2), 64'(32'h1000_0000 + 32'(g.rq * 16)));
          chk("user", 64'(us0), 64'(32'hC0DE_0000 + 32'(g.rq)));
          chk("id", 64'(id0), 64'(g.rq % 2));
          chk("wstrb", 64'(ws0), 64'(4'h1 << g.rq));
          chk("write", 64'({wr0, wr2}), 64'({g.wr, g.wr}));
          chk("last", 64'({ls0, ls2}), 64'({g.lst, g.lst}));
          chk("wdata", 64'({wd0, wd2}), {g.wd, g.wd});
          chk("req_hld_grant", 64'({rh0, rh2}), 64'({~oh, ~oh}));
          chk("req_wr_err", 64'({we0, we2}), g.werr ? 64'({oh, oh}) : 64'd0);
        end
      end else begin
        chk("wr_err_idle", 64'({we0, we2}), 64'd0);
      end
      if (rv0 != 3'b000) begin
        if (r0q.size() == 0) chk("ret_c0_unexpected", 64'(rv0), 64'd0);
        else begin
          r  = r0q.pop_front();
          oh = 3'b001 << r.rq;
          chk("rvalid_c0_owner", 64'(rv0), 64'(oh));
          chk("rd_err_c0", 64'(re0), r.err ? 64'(oh) : 64'd0);
          chk("rdata_c0", 64'(rd0), 64'(rdata));
        end
      end else chk("rd_err_c0_idle", 64'(re0), 64'd0);
      if (rv2 != 3'b000) begin
        if (r2q.size() == 0) chk("ret_c2_unexpected", 64'(rv2), 64'd0);
        else begin
          r  = r2q.pop_front();
          oh = 3'b001 << r.rq;
          chk("rvalid_c2_owner", 64'(rv2), 64'(oh));
          chk("rd_err_c2", 64'(re2), r.err ? 64'(oh) : 64'd0);
          chk("rdata_c2", 64'(rd2), 64'(rdata));
        end
      end else chk("rd_err_c2_idle", 64'(re2), 64'd0);
      if (done && !fin) begin
        chk("grants_left", 64'(gq.size()), 64'd0);
        chk("ret_c0_left", 64'(r0q.size()), 64'd0);
        chk("ret_c2_left", 64'(r2q.size()), 64'd0);
        fin = 1'b1;
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_dv = '0; req_write = '0; req_last = '0;
    hld = 1'b0; rd_err = 1'b0; wr_err = 1'b0; perf_clr = 1'b0; rdata = '0;
    for (int i = 0; i < NRQ; i++) begin
      req_addr[i*32 +: 32]  = 32'h1000_0000 + 32'(i * 16);
      req_user[i*32 +: 32]  = 32'hC0DE_0000 + 32'(i);
      req_wdata[i*32 +: 32] = 32'hDA7A_0000 + 32'(i);
      req_id[i]             = 1'(i % 2);
      req_wstrb[i*4 +: 4]   = 4'h1 << i;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset
    probe(0, 48'd0); probe(1, 48'h7); probe(2, 48'd0); probe(3, 48'd0);
    cyc(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

    // All three request single-beat reads: 0,1,2,0
    for (int k = 0; k < 4; k++) begin
      push_g(k % 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(3'b111, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0);
    end

    // Requester 1 write burst of 4 with others waiting, wr_err on beat 3
    for (int k = 1; k <= 4; k++) begin
      req_wdata[63:32] = 32'hB0B0_0000 + 32'(k);
      push_g(1, 1'b1, k == 4, k == 3, 1'b0, 1'b0, 1'b1);
      probe(1, 48'h5);
      cyc(3'b111, 3'b010, (k == 4) ? 3'b111 : 3'b101, 1'b0, k == 3, 1'b0);
    end
    req_wdata[63:32] = 32'hDA7A_0001;
    push_g(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(3'b101, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0);
    push_g(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(3'b101, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0);

    // Read req 0 then req 2; rd_err only when req 2's delayed data returns
    push_g(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(3'b001, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0);
    push_g(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(3'b100, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0);
    cyc(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    cyc(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);

    // Req 1 burst stalled by hld for 3 cycles, then owner drops dv for one
    req_wdata[63:32] = 32'hC1C1_0001;
    push_g(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(3'b010, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      probe(0, 48'd1); probe(1, 48'h7);
      cyc(3'b111, 3'b010, 3'b101, 1'b1, 1'b1, 1'b0);
    end
    probe(0, 48'd0); probe(1, 48'h5);
    cyc(3'b101, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0);
    req_wdata[63:32] = 32'hC1C1_0002;
    push_g(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(3'b111, 3'b010, 3'b101, 1'b0, 1'b0, 1'b0);
    req_wdata[63:32] = 32'hC1C1_0003;
    push_g(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(3'b111, 3'b010, 3'b111, 1'b0, 1'b0, 1'b0);
    req_wdata[63:32] = 32'hDA7A_0001;
    push_g(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(3'b101, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a locked read burst with returns in flight
    push_g(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(3'b001, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0);
    push_g(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(3'b010, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    push_g(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(3'b010, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    req_dv = 3'b000;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    probe(0, 48'd0); probe(1, 48'h7); probe(2, 48'd0);
    cyc(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    push_g(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(3'b111, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

`ifdef AXI_SUB_ARB_MP_PERF_EN
    // Saturate requester 0's counter, then clear it alongside an accept
    mon_en = 1'b0;
    req_dv = 3'b001; req_write = 3'b000; req_last = 3'b111;
    repeat (70000) @(posedge clk);
    #1;
    req_dv = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    push_g(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    probe(3, 48'h0000_0000_FFFF);
    perf_clr = 1'b1;
    cyc(3'b001, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0);
    perf_clr = 1'b0;
    probe(3, 48'd0);
    cyc(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
`else
    probe(3, 48'd0);
    cyc(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
`endif

    done = 1'b1;
    repeat (3) @(posedge clk);
    if (!fin) begin
      $display("FAIL end_of_run monitor did not complete: fin=%0b required=1", fin);
      $fatal(1, "monitor stalled");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
